// File: rtl/s3g_int_reporter.sv
// s3g_int_reporter: interrupt aggregation and report requester for the S3G link.
// Latches edge/level sources into a pending register, applies a mask and
// write-1-to-clear, and hands pending&mask snapshots to the s3g_tx arbiter.
// Optional feature macro: INT_REREPORT_EN (periodic re-report of still-pending
// unmasked interrupts every INTS_TIMER cycles). Undefined: no holdoff timer.
module s3g_int_reporter #(
    parameter int unsigned         NUM_INTS    = 32,
    parameter logic [NUM_INTS-1:0] EDGE_MASK   = {NUM_INTS{1'b1}},
    parameter int unsigned         INTS_TIMER  = 1000000,
    parameter int unsigned         TIMER_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_INTS-1:0] ints_in,
    input  logic                mask_stb,
    input  logic [NUM_INTS-1:0] mask_data,
    input  logic                clr_stb,
    input  logic [NUM_INTS-1:0] clr_data,
    output logic                report_req,
    output logic [NUM_INTS-1:0] report_ints,
    input  logic                report_ack,
    output logic [NUM_INTS-1:0] ints_pending,
    output logic [NUM_INTS-1:0] ints_mask
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD
    } state_t;

    state_t              r_state;
    logic [NUM_INTS-1:0] r_prev;
    logic [NUM_INTS-1:0] r_pending;
    logic [NUM_INTS-1:0] r_mask;
    logic [NUM_INTS-1:0] r_reported;
    logic [NUM_INTS-1:0] r_report_ints;
    logic                r_report_req;

    logic [NUM_INTS-1:0] w_set;
    logic [NUM_INTS-1:0] w_clr;
    logic [NUM_INTS-1:0] w_active;
    logic [NUM_INTS-1:0] w_new;
    logic                w_expired;

    // Source detection, clear qualification and the active/new-bit views
    always_comb begin
        // Edge channels see the rising edge only; level channels pass straight through
        w_set    = ints_in & ~(r_prev & EDGE_MASK);
        w_clr    = clr_stb ? clr_data : '0;
        w_active = r_pending & r_mask;
        w_new    = w_active & ~r_reported;
    end

`ifdef INT_REREPORT_EN
    localparam logic [TIMER_WIDTH-1:0] LP_RELOAD = TIMER_WIDTH'(INTS_TIMER - 1);

    logic [TIMER_WIDTH-1:0] r_timer;

    assign w_expired = (r_timer == '0);

    // Holdoff countdown: loaded on report ack, saturates at zero while holding
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (r_state == ST_REQ && report_ack) begin
            r_timer <= LP_RELOAD;
        end else if (r_state == ST_HOLD && r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
        end
    end
`else
    assign w_expired = 1'b0;
`endif

    // Edge history, pending register (set wins over clear) and mask register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev    <= '0;
            r_pending <= '0;
            r_mask    <= '1;
        end else begin
            r_prev    <= ints_in;
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (mask_stb) begin
                r_mask <= mask_data;
            end
        end
    end

    // Report FSM: request, wait for ack, then hold off until new bits or expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_report_req  <= 1'b0;
            r_report_ints <= '0;
            r_reported    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_active != '0) begin
                        r_state       <= ST_REQ;
                        r_report_req  <= 1'b1;
                        r_report_ints <= w_active;
                        r_reported    <= w_active;
                    end
                end
                ST_REQ: begin
                    if (report_ack) begin
                        r_state      <= ST_HOLD;
                        r_report_req <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (w_active == '0) begin
                        r_state <= ST_IDLE;
                    end else if (w_new != '0 || w_expired) begin
                        r_state       <= ST_REQ;
                        r_report_req  <= 1'b1;
                        r_report_ints <= w_active;
                        r_reported    <= w_active;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_report_req <= 1'b0;
                end
            endcase
        end
    end

    assign report_req   = r_report_req;
    assign report_ints  = r_report_ints;
    assign ints_pending = r_pending;
    assign ints_mask    = r_mask;

endmodule

// File: tb/tb_s3g_int_reporter.sv
// tb_s3g_int_reporter: directed scenarios plus randomized traffic for
// s3g_int_reporter, checked against a behavioural model of the report rules.
module tb_s3g_int_reporter;

    localparam int unsigned N    = 32;
    localparam logic [31:0] EDGE = 32'hFFFF_FFFB;
    localparam int unsigned TMR  = 100;
`ifdef INT_REREPORT_EN
    localparam bit REREPORT = 1'b1;
`else
    localparam bit REREPORT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  ints_in;
    logic          mask_stb;
    logic [N-1:0]  mask_data;
    logic          clr_stb;
    logic [N-1:0]  clr_data;
    logic          report_req;
    logic [N-1:0]  report_ints;
    logic          report_ack;
    logic [N-1:0]  ints_pending;
    logic [N-1:0]  ints_mask;

    always #5 clk = ~clk;

    s3g_int_reporter #(
        .NUM_INTS   (N),
        .EDGE_MASK  (EDGE),
        .INTS_TIMER (TMR),
        .TIMER_WIDTH(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ints_in     (ints_in),
        .mask_stb    (mask_stb),
        .mask_data   (mask_data),
        .clr_stb     (clr_stb),
        .clr_data    (clr_data),
        .report_req  (report_req),
        .report_ints (report_ints),
        .report_ack  (report_ack),
        .ints_pending(ints_pending),
        .ints_mask   (ints_mask)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model state
    logic [31:0] m_prev, m_pend, m_mask, m_rep, m_reported;
    bit          m_req, m_hold;
    int          m_wait;
    int          req_age;
    bit          ack_auto;
    int          ack_delay;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of the reference behaviour, using the inputs sampled at this edge
    task automatic model_step();
        logic [31:0] act;
        logic [31:0] setv;
        if (rst) begin
            m_prev = '0; m_pend = '0; m_mask = '1; m_rep = '0; m_reported = '0;
            m_req = 1'b0; m_hold = 1'b0; m_wait = 0;
        end else begin
            act = m_pend & m_mask;
            if (m_req) begin
                if (report_ack) begin
                    m_req = 1'b0; m_hold = 1'b1; m_wait = TMR - 1;
                end
            end else if (m_hold) begin
                if (act == 0) begin
                    m_hold = 1'b0;
                end else if ((act & ~m_reported) != 0 || (REREPORT && m_wait == 0)) begin
                    m_hold = 1'b0; m_req = 1'b1; m_rep = act; m_reported = act;
                end else if (m_wait > 0) begin
                    m_wait--;
                end
            end else if (act != 0) begin
                m_req = 1'b1; m_rep = act; m_reported = act;
            end
            setv = '0;
            for (int unsigned i = 0; i < N; i++) begin
                if (EDGE[i]) setv[i] = ints_in[i] && !m_prev[i];
                else         setv[i] = ints_in[i];
            end
            m_pend = (m_pend & ~(clr_stb ? clr_data : 32'h0)) | setv;
            m_prev = ints_in;
            if (mask_stb) m_mask = mask_data;
        end
        req_age = m_req ? req_age + 1 : 0;
    endtask

    task automatic tick();
        if (ack_auto) report_ack = m_req && (req_age >= ack_delay);
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("report_req",   report_req,   m_req);
        chk("report_ints",  report_ints,  m_rep);
        chk("ints_pending", ints_pending, m_pend);
        chk("ints_mask",    ints_mask,    m_mask);
    endtask

    // Returns ticks until DUT report_req is seen high, or -1 if not within max
    task automatic wait_dut_req(input int max, output int n);
        n = -1;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (report_req === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_dut_drop(input string tag, input int max);
        for (int k = 0; k < max; k++) begin
            if (report_req === 1'b0) break;
            tick();
        end
        chk(tag, report_req, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; ints_in = '0; mask_stb = 1'b0; mask_data = '0;
        clr_stb = 1'b0; clr_data = '0; report_ack = 1'b0;
        m_prev = '0; m_pend = '0; m_mask = '1; m_rep = '0; m_reported = '0;
        m_req = 1'b0; m_hold = 1'b0; m_wait = 0; req_age = 0;
        ack_auto = 1'b1; ack_delay = 5;

        // Reset state
        tick(); tick();
        chk("rst_req",     report_req,   1'b0);
        chk("rst_pending", ints_pending, 32'h0);
        chk("rst_mask",    ints_mask,    32'hFFFF_FFFF);
        chk("rst_rints",   report_ints,  32'h0);
        rst = 1'b0;
        repeat (8) tick();

        // Scenario 1: edge on bit 31 -> pending next cycle, request the one after
        ints_in[31] = 1'b1;
        tick();
        chk("s1_pending", ints_pending, 32'h8000_0000);
        chk("s1_req_early", report_req, 1'b0);
        tick();
        chk("s1_req", report_req, 1'b1);
        chk("s1_rints", report_ints, 32'h8000_0000);
        wait_dut_drop("s1_ack_drop", 20);

        // Scenario 2: uncleared bit 31 and periodic re-report
`ifdef INT_REREPORT_EN
        for (int r = 0; r < 2; r++) begin
            wait_dut_req(TMR + 50, n);
            chk("s2_gap", n, TMR);
            chk("s2_rints", report_ints, 32'h8000_0000);
            wait_dut_drop("s2_ack_drop", 20);
        end
`else
        wait_dut_req(1000, n);
        chk("s2_no_rereport", n, -1);
`endif

        // Scenario 3: full mask in HOLD, then unmask
        mask_stb = 1'b1; mask_data = 32'h7FFF_FFFF;
        tick();
        mask_stb = 1'b0;
        chk("s3_mask", ints_mask, 32'h7FFF_FFFF);
        wait_dut_req(500, n);
        chk("s3_quiet", n, -1);
        chk("s3_pending", ints_pending, 32'h8000_0000);
        mask_stb = 1'b1; mask_data = 32'hFFFF_FFFF;
        tick();
        mask_stb = 1'b0;
        wait_dut_req(TMR, n);
        chk("s3_unmask_req", report_req, 1'b1);
        chk("s3_unmask_rints", report_ints, 32'h8000_0000);
        wait_dut_drop("s3_ack_drop", 20);

        // Scenario 4: clear, then set-wins-over-clear
        clr_stb = 1'b1; clr_data = 32'h8000_0000;
        tick();
        clr_stb = 1'b0;
        chk("s4_clr31", ints_pending, 32'h0);
        ints_in[7] = 1'b1;
        wait_dut_req(5, n);
        chk("s4_rints7", report_ints, 32'h0000_0080);
        wait_dut_drop("s4_ack_drop", 20);
        clr_stb = 1'b1; clr_data = 32'h0000_0080;
        tick();
        clr_stb = 1'b0;
        chk("s4_clr7", ints_pending, 32'h0);
        wait_dut_req(50, n);
        chk("s4_no_req", n, -1);
        ints_in[7] = 1'b0;
        tick();
        ints_in[7] = 1'b1; clr_stb = 1'b1; clr_data = 32'h0000_0080;
        tick();
        clr_stb = 1'b0;
        chk("s4_set_wins", ints_pending, 32'h0000_0080);
        wait_dut_req(5, n);
        wait_dut_drop("s4_ack_drop2", 20);
        clr_stb = 1'b1; clr_data = '1; ints_in = '0;
        tick();
        clr_stb = 1'b0;
        repeat (3) tick();

        // Scenario 5: new bit during HOLD bypasses the holdoff
        ints_in[0] = 1'b1;
        wait_dut_req(5, n);
        chk("s5_rints1", report_ints, 32'h0000_0001);
        wait_dut_drop("s5_ack_drop", 20);
        repeat (3) tick();
        ints_in[4] = 1'b1;
        wait_dut_req(10, n);
        chk("s5_latency", n, 2);
        chk("s5_rints", report_ints, 32'h0000_0011);
        wait_dut_drop("s5_ack_drop2", 20);
        clr_stb = 1'b1; clr_data = '1; ints_in = '0;
        tick();
        clr_stb = 1'b0;
        repeat (3) tick();

        // Scenario 6: reset mid-handshake, then a level channel beats clear
        ack_delay = 1000;
        ints_in[9] = 1'b1;
        wait_dut_req(5, n);
        chk("s6_req_up", report_req, 1'b1);
        rst = 1'b1; ints_in = '0;
        tick();
        rst = 1'b0;
        chk("s6_req_drop", report_req, 1'b0);
        chk("s6_pending", ints_pending, 32'h0);
        chk("s6_mask", ints_mask, 32'hFFFF_FFFF);
        ack_delay = 3;
        ints_in[2] = 1'b1; clr_stb = 1'b1; clr_data = 32'h0000_0004;
        repeat (4) begin
            tick();
            chk("s6_level", ints_pending & 32'h4, 32'h4);
        end
        clr_stb = 1'b0; ints_in = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Randomized traffic with spurious acks and occasional resets
        ack_auto = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            ints_in   = ints_in ^ ($urandom & $urandom & $urandom & $urandom);
            mask_stb  = ($urandom_range(0, 15) == 0);
            mask_data = $urandom | $urandom;
            clr_stb   = ($urandom_range(0, 5) == 0);
            clr_data  = $urandom;
            report_ack = m_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; report_ack = 1'b0; mask_stb = 1'b0; clr_stb = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
